// File: rtl/dm_hart_array_ctrl.sv
// dm_hart_array_ctrl
//   Per-hart run-control engine for the debug module. It turns dmcontrol
//   halt/resume requests into per-hart request levels, tracks each hart's run
//   state, flags halt requests that time out, and builds the dmstatus
//   any*/all* summaries over the selected harts (hartsel plus hart-array mask).
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   dmactive_i               low acts as a synchronous clear, same as rst_i
//   hartsel_i, hasel_i,
//   hamask_i                 hart selection: single index plus optional window mask
//   haltreq_i, resumereq_i   dmcontrol requests (level / one-cycle pulse)
//   halted_i, resuming_i     per-hart pulses from dm_mem
//   unavailable_i            per-hart power-down / unavailable level
//   debug_req_o, resume_o    per-hart request levels
//   halted_o, resumeack_o,
//   haltto_o                 per-hart status (resumeack/haltto are sticky)
//   any*/all*_o              dmstatus summaries over the selected harts
//
// state        | meaning
// -------------+----------------------------------------------------
// ST_RUNNING   | hart executing normally
// ST_HALT_PEND | debug_req asserted, waiting for the hart to halt
// ST_HALTED    | hart is in debug mode
// ST_RESUME_PEND | resume asserted, waiting for the hart to leave debug

module dm_hart_array_ctrl #(
  parameter int unsigned        NrHarts         = 4,
  parameter logic [NrHarts-1:0] SelectableHarts = {NrHarts{1'b1}},
  parameter int unsigned        HaltTimeout     = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               dmactive_i,
  input  logic [19:0]        hartsel_i,
  input  logic               hasel_i,
  input  logic [NrHarts-1:0] hamask_i,
  input  logic               haltreq_i,
  input  logic               resumereq_i,
  input  logic [NrHarts-1:0] halted_i,
  input  logic [NrHarts-1:0] resuming_i,
  input  logic [NrHarts-1:0] unavailable_i,
  output logic [NrHarts-1:0] debug_req_o,
  output logic [NrHarts-1:0] resume_o,
  output logic [NrHarts-1:0] halted_o,
  output logic [NrHarts-1:0] resumeack_o,
  output logic [NrHarts-1:0] haltto_o,
  output logic               anyhalted_o,
  output logic               allhalted_o,
  output logic               anyrunning_o,
  output logic               allrunning_o,
  output logic               anyresumeack_o,
  output logic               allresumeack_o,
  output logic               anyunavail_o,
  output logic               allunavail_o,
  output logic               anynonexistent_o,
  output logic               allnonexistent_o
);

  // A zero timeout disables the counter; keep it one bit wide so it still elaborates.
  localparam int unsigned     CntW   = (HaltTimeout > 0) ? $clog2(HaltTimeout + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HaltTimeout);

  typedef enum logic [1:0] {
    ST_RUNNING,
    ST_HALT_PEND,
    ST_HALTED,
    ST_RESUME_PEND
  } hart_state_e;

  hart_state_e         state_q [NrHarts];
  hart_state_e         state_d [NrHarts];
  logic [CntW-1:0]     cnt_q   [NrHarts];
  logic [CntW-1:0]     cnt_d   [NrHarts];
  logic [NrHarts-1:0]  ack_q, ack_d;
  logic [NrHarts-1:0]  to_q, to_d;

  logic                clr;
  logic [NrHarts-1:0]  hit, sel, hreq;
  logic [NrHarts-1:0]  st_halted, st_pend, st_rpend, st_running;
  logic [NrHarts-1:0]  v_halted, v_running, v_ack;
  logic                sel_any, nonexist;

  assign clr = rst_i | ~dmactive_i;

  always_comb begin
    for (int i = 0; i < NrHarts; i++) begin
      hit[i] = (hartsel_i == 20'(i));
      sel[i] = (hit[i] | (hasel_i & hamask_i[i])) & SelectableHarts[i];
    end
  end

  assign hreq = {NrHarts{haltreq_i}} & sel;

  always_comb begin
    for (int i = 0; i < NrHarts; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      ack_d[i]   = ack_q[i];
      to_d[i]    = to_q[i];
      if (unavailable_i[i]) begin
        state_d[i] = ST_RUNNING;
      end else begin
        unique case (state_q[i])
          ST_RUNNING: begin
            // A halted pulse is never dropped: the hart is already in debug mode.
            if (halted_i[i]) begin
              state_d[i] = ST_HALTED;
            end else if (hreq[i]) begin
              state_d[i] = ST_HALT_PEND;
              to_d[i]    = 1'b0;
            end
          end
          ST_HALT_PEND: begin
            if (halted_i[i])    state_d[i] = ST_HALTED;
            else if (!hreq[i])  state_d[i] = ST_RUNNING;
          end
          ST_HALTED: begin
            if (resumereq_i && sel[i] && !haltreq_i) begin
              state_d[i] = ST_RESUME_PEND;
              ack_d[i]   = 1'b0;
            end
          end
          ST_RESUME_PEND: begin
            if (resuming_i[i]) begin
              state_d[i] = ST_RUNNING;
              ack_d[i]   = 1'b1;
            end
          end
          default: state_d[i] = ST_RUNNING;
        endcase
      end
      // Counter only advances while the hart stays in HALT_PEND; any exit clears it.
      if (HaltTimeout != 0 && state_q[i] == ST_HALT_PEND && state_d[i] == ST_HALT_PEND) begin
        cnt_d[i] = (cnt_q[i] == CntMax) ? cnt_q[i] : cnt_q[i] + CntW'(1);
        if (cnt_d[i] == CntMax) to_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      for (int i = 0; i < NrHarts; i++) begin
        state_q[i] <= ST_RUNNING;
        cnt_q[i]   <= '0;
      end
      ack_q <= '0;
      to_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NrHarts; i++) begin
      st_halted[i]  = (state_q[i] == ST_HALTED);
      st_pend[i]    = (state_q[i] == ST_HALT_PEND);
      st_rpend[i]   = (state_q[i] == ST_RESUME_PEND);
      st_running[i] = (state_q[i] == ST_RUNNING) | st_pend[i];
    end
  end

  assign debug_req_o = st_pend  & ~unavailable_i;
  assign resume_o    = st_rpend & ~unavailable_i;
  assign halted_o    = st_halted;
  assign resumeack_o = ack_q;
  assign haltto_o    = to_q;

  // Unavailable harts only contribute to the unavail summaries.
  assign v_halted  = st_halted  & ~unavailable_i;
  assign v_running = st_running & ~unavailable_i;
  assign v_ack     = ack_q      & ~unavailable_i;
  assign sel_any   = |sel;

  assign anyhalted_o    = ~clr & |(sel & v_halted);
  assign allhalted_o    = ~clr & sel_any & (&(~sel | v_halted));
  assign anyrunning_o   = ~clr & |(sel & v_running);
  assign allrunning_o   = ~clr & sel_any & (&(~sel | v_running));
  assign anyresumeack_o = ~clr & |(sel & v_ack);
  assign allresumeack_o = ~clr & sel_any & (&(~sel | v_ack));
  assign anyunavail_o   = ~clr & |(sel & unavailable_i);
  assign allunavail_o   = ~clr & sel_any & (&(~sel | unavailable_i));

  // Out-of-range or absent hartsel; meaningless once the hart-array mask is in use.
  assign nonexist         = ~hasel_i & ~|(hit & SelectableHarts);
  assign anynonexistent_o = nonexist;
  assign allnonexistent_o = nonexist;

endmodule
